// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared types and legality limits for the staged reset sequencer.
package reset_seq_pkg;

  // Sequencer phases: hold everything in reset, pace out releases, finished.
  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_GAP  = 2'd1,
    S_DONE = 2'd2
  } rst_seq_state_e;

  localparam int MIN_SYNC_STAGE = 2;
  localparam int MAX_NUM_CH     = 16;
  localparam int MIN_GAP_CYC    = 1;

  // Channel index width; a single channel still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_seq_if.sv
// reset_seq_if: per-channel reset outputs, completion flag and (with
// RESET_SEQ_SWRST_EN) the synchronous software reset request.
interface reset_seq_if
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH = 4
);

  if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
    $error("reset_seq_if: NUM_CH=%0d out of range 1..%0d", NUM_CH, MAX_NUM_CH);
  end

  logic [NUM_CH-1:0] o_rst_n;
  logic              o_done;

`ifdef RESET_SEQ_SWRST_EN
  logic              i_sw_rst;

  modport master (output o_rst_n, output o_done, input  i_sw_rst);
  modport slave  (input  o_rst_n, input  o_done, output i_sw_rst);
`else
  modport master (output o_rst_n, output o_done);
  modport slave  (input  o_rst_n, input  o_done);
`endif

endinterface

// File: rtl/reset_seq_sync.sv
// reset_sync_cell: SYNC_STAGE-deep reset synchroniser. Assertion is
// asynchronous, release is aligned to clk. This is the single point where a
// technology synchroniser cell would be substituted for ASIC flows.
module reset_sync_cell
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGE = 3
) (
  input  logic clk,
  input  logic i_rst,
  output logic sync_out
);

  if (SYNC_STAGE < MIN_SYNC_STAGE) begin : g_bad_sync_stage
    $error("reset_sync_cell: SYNC_STAGE=%0d below minimum %0d", SYNC_STAGE, MIN_SYNC_STAGE);
  end

  logic [SYNC_STAGE-1:0] chain;

  // Clear on reset, then walk a 1 through the chain; last flop is the release.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) chain <= '0;
    else       chain <= {chain[SYNC_STAGE-2:0], 1'b1};
  end

  assign sync_out = chain[SYNC_STAGE-1];

endmodule

// File: rtl/reset_seq.sv
// reset_seq: synchronises i_rst into clk and releases NUM_CH active-low
// resets one by one in index order, GAP_CYC cycles apart, then raises o_done.
// Optional: define RESET_SEQ_SWRST_EN to add the synchronous i_sw_rst request
// that replays the release sequence without touching the synchroniser.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGE = 3,
  parameter int NUM_CH     = 4,
  parameter int GAP_CYC    = 8
) (
  input  logic        clk,
  input  logic        i_rst,
  reset_seq_if.master bus
);

  localparam int CNT_W = $clog2(GAP_CYC + 1);
  localparam int IDX_W = idx_width(NUM_CH);

  if (NUM_CH < 1 || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
    $error("reset_seq: NUM_CH=%0d out of range 1..%0d", NUM_CH, MAX_NUM_CH);
  end
  if (GAP_CYC < MIN_GAP_CYC) begin : g_bad_gap
    $error("reset_seq: GAP_CYC=%0d below minimum %0d", GAP_CYC, MIN_GAP_CYC);
  end

  logic              sync_done;
  logic              sw_req;

  rst_seq_state_e    state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [NUM_CH-1:0] rst_n_q, rst_n_d;
  logic              done_q,  done_d;

  reset_sync_cell #(
    .SYNC_STAGE (SYNC_STAGE)
  ) u_sync (
    .clk      (clk),
    .i_rst    (i_rst),
    .sync_out (sync_done)
  );

`ifdef RESET_SEQ_SWRST_EN
  assign sw_req = bus.i_sw_rst;
`else
  assign sw_req = 1'b0;
`endif

  // State, pacing counter, channel index and the output flops. Outputs are
  // registered with async clear so a reset of any width drops them at once.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  // Next-state: a software request wins over everything and parks in S_HOLD;
  // otherwise count down the gap and release the indexed channel at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    if (sw_req) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (sync_done) begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(GAP_CYC - 1);
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (idx_q == IDX_W'(k)) rst_n_d[k] = 1'b1;
            end
            if (idx_q == IDX_W'(NUM_CH - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
              cnt_d = CNT_W'(GAP_CYC - 1);
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_DONE:  ;
        default: state_d = S_HOLD;
      endcase
    end
  end

  assign bus.o_rst_n = rst_n_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_reset_seq.sv
// tb_reset_seq: randomised and directed checks of reset_seq against a model
// that derives release edges from the edge count since the last reset.
module tb_reset_seq;

  localparam int S  = 3, G  = 8, N  = 4;
  localparam int MS = 2, MG = 1, MN = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reset_seq_if #(.NUM_CH(N))  bus();
  reset_seq_if #(.NUM_CH(MN)) bus_min();

  reset_seq #(.SYNC_STAGE(S), .NUM_CH(N), .GAP_CYC(G)) dut (
    .clk(clk), .i_rst(rst), .bus(bus.master));

  reset_seq #(.SYNC_STAGE(MS), .NUM_CH(MN), .GAP_CYC(MG)) dut_min (
    .clk(clk), .i_rst(rst), .bus(bus_min.master));

`ifdef RESET_SEQ_SWRST_EN
  logic sw = 1'b0;
  assign bus.i_sw_rst     = sw;
  assign bus_min.i_sw_rst = 1'b0;
`endif

  int tests_run = 0, tests_failed = 0;

  // Model state: edges since i_rst fell, and the last edge that sampled a sw request.
  int n = 0, lsw = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      n   <= 0;
      lsw <= 0;
    end else begin
      n <= n + 1;
`ifdef RESET_SEQ_SWRST_EN
      if (sw) lsw <= n + 1;
`endif
    end
  end

  // Releases start from anchor A = max(sync done + 1, last sw edge + 1);
  // channel k is free from edge A + (k+1)*g onward.
  function automatic logic [15:0] exp_rst(input int ne, input int ls, input int s, input int g,
                                          input int nch);
    logic [15:0] r;
    int a;
    r = '0;
    if (ne == 0) return r;
    a = s + 1;
    if (ls + 1 > a) a = ls + 1;
    for (int k = 0; k < nch; k++) if (ne >= a + (k + 1) * g) r[k] = 1'b1;
    return r;
  endfunction

  logic [15:0] e, em;
  logic        ed, edm;

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      tests_run++;
      if ({bus.o_done, bus.o_rst_n} !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_hold got done=%b rst_n=%b exp 0/0000", bus.o_done, bus.o_rst_n);
      end
      tests_run++;
      if ({bus_min.o_done, bus_min.o_rst_n} !== 2'b0) begin
        tests_failed++;
        $display("FAIL reset_hold_min got done=%b rst_n=%b exp 0/0", bus_min.o_done, bus_min.o_rst_n);
      end
    end
  endtask

  task automatic test_power_on();
    rst = 1'b0;
    repeat (45) begin
      @(negedge clk);
      e = '0;
      for (int k = 0; k < N; k++) if (n >= 12 + 8 * k) e[k] = 1'b1;
      ed = (n >= 36);
      tests_run++;
      if ({bus.o_done, bus.o_rst_n} !== {ed, e[N-1:0]}) begin
        tests_failed++;
        $display("FAIL power_on n=%0d got done=%b rst_n=%b exp done=%b rst_n=%b",
                 n, bus.o_done, bus.o_rst_n, ed, e[N-1:0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (22) @(negedge clk);
    tests_run++;
    if ({bus.o_done, bus.o_rst_n} !== 5'b0_0011) begin
      tests_failed++;
      $display("FAIL mid_pre n=%0d got done=%b rst_n=%b exp 0/0011", n, bus.o_done, bus.o_rst_n);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.o_done, bus.o_rst_n} !== 5'b0) begin
      tests_failed++;
      $display("FAIL mid_async got done=%b rst_n=%b exp 0/0000", bus.o_done, bus.o_rst_n);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      e = exp_rst(n, lsw, S, G, N);
      ed = (e[N-1:0] == '1);
      tests_run++;
      if ({bus.o_done, bus.o_rst_n} !== {ed, e[N-1:0]}) begin
        tests_failed++;
        $display("FAIL mid_replay n=%0d got done=%b rst_n=%b exp done=%b rst_n=%b",
                 n, bus.o_done, bus.o_rst_n, ed, e[N-1:0]);
      end
    end
  endtask

  task automatic test_glitch();
    tests_run++;
    if ({bus.o_done, bus.o_rst_n} !== 5'b1_1111) begin
      tests_failed++;
      $display("FAIL glitch_pre got done=%b rst_n=%b exp 1/1111", bus.o_done, bus.o_rst_n);
    end
    #1 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.o_done, bus.o_rst_n} !== 5'b0) begin
      tests_failed++;
      $display("FAIL glitch_async got done=%b rst_n=%b exp 0/0000", bus.o_done, bus.o_rst_n);
    end
    #1 rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      e = exp_rst(n, lsw, S, G, N);
      ed = (e[N-1:0] == '1);
      tests_run++;
      if ({bus.o_done, bus.o_rst_n} !== {ed, e[N-1:0]}) begin
        tests_failed++;
        $display("FAIL glitch_replay n=%0d got done=%b rst_n=%b exp done=%b rst_n=%b",
                 n, bus.o_done, bus.o_rst_n, ed, e[N-1:0]);
      end
    end
  endtask

  task automatic test_min_config();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      tests_run++;
      if ({bus_min.o_done, bus_min.o_rst_n} !== ((n >= 4) ? 2'b11 : 2'b00)) begin
        tests_failed++;
        $display("FAIL min_cfg n=%0d got done=%b rst_n=%b exp edge 4 release",
                 n, bus_min.o_done, bus_min.o_rst_n);
      end
    end
  endtask

  task automatic test_random();
    int hold, r;
    hold = 0;
    repeat (800) begin
      @(negedge clk);
      e  = exp_rst(n, lsw, S, G, N);
      ed = (e[N-1:0] == '1);
      em = exp_rst(n, 0, MS, MG, MN);
      edm = em[0];
      tests_run++;
      if ({bus.o_done, bus.o_rst_n} !== {ed, e[N-1:0]}) begin
        tests_failed++;
        $display("FAIL random n=%0d lsw=%0d got done=%b rst_n=%b exp done=%b rst_n=%b",
                 n, lsw, bus.o_done, bus.o_rst_n, ed, e[N-1:0]);
      end
      tests_run++;
      if ({bus_min.o_done, bus_min.o_rst_n} !== {edm, em[0]}) begin
        tests_failed++;
        $display("FAIL random_min n=%0d got done=%b rst_n=%b exp done=%b rst_n=%b",
                 n, bus_min.o_done, bus_min.o_rst_n, edm, em[0]);
      end
      r = int'($urandom_range(0, 199));
      if (hold > 0) begin
        hold--;
        if (hold == 0) rst = 1'b0;
      end else if (r < 2) begin
        rst  = 1'b1;
        hold = int'($urandom_range(1, 4));
      end else if (r == 2) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
`ifdef RESET_SEQ_SWRST_EN
      if (sw) begin
        if (r % 3 == 0) sw = 1'b0;
      end else if (r == 3 || r == 4) begin
        sw = 1'b1;
      end
`endif
    end
    rst = 1'b0;
`ifdef RESET_SEQ_SWRST_EN
    sw = 1'b0;
`endif
  endtask

`ifdef RESET_SEQ_SWRST_EN
  task automatic test_sw_done();
    int ee;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    tests_run++;
    if ({bus.o_done, bus.o_rst_n} !== 5'b1_1111) begin
      tests_failed++;
      $display("FAIL sw_pre got done=%b rst_n=%b exp 1/1111", bus.o_done, bus.o_rst_n);
    end
    sw = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.o_done, bus.o_rst_n} !== 5'b0) begin
      tests_failed++;
      $display("FAIL sw_assert got done=%b rst_n=%b exp 0/0000", bus.o_done, bus.o_rst_n);
    end
    repeat (2) @(negedge clk);
    sw = 1'b0;
    ee = n + 1;
    repeat (40) begin
      @(negedge clk);
      e = '0;
      for (int k = 0; k < N; k++) if (n >= ee + (k + 1) * G) e[k] = 1'b1;
      ed = (n >= ee + N * G);
      tests_run++;
      if ({bus.o_done, bus.o_rst_n} !== {ed, e[N-1:0]}) begin
        tests_failed++;
        $display("FAIL sw_replay n=%0d E=%0d got done=%b rst_n=%b exp done=%b rst_n=%b",
                 n, ee, bus.o_done, bus.o_rst_n, ed, e[N-1:0]);
      end
    end
  endtask

  task automatic test_sw_hold();
    int ee;
    rst = 1'b1;
    sw  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      tests_run++;
      if ({bus.o_done, bus.o_rst_n} !== 5'b0) begin
        tests_failed++;
        $display("FAIL sw_hold n=%0d got done=%b rst_n=%b exp 0/0000", n, bus.o_done, bus.o_rst_n);
      end
    end
    sw = 1'b0;
    ee = n + 1;
    repeat (40) begin
      @(negedge clk);
      e = '0;
      for (int k = 0; k < N; k++) if (n >= ee + (k + 1) * G) e[k] = 1'b1;
      ed = (n >= ee + N * G);
      tests_run++;
      if ({bus.o_done, bus.o_rst_n} !== {ed, e[N-1:0]}) begin
        tests_failed++;
        $display("FAIL sw_hold_rel n=%0d E=%0d got done=%b rst_n=%b exp done=%b rst_n=%b",
                 n, ee, bus.o_done, bus.o_rst_n, ed, e[N-1:0]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_power_on();
    test_mid_reset();
    test_glitch();
    test_min_config();
`ifdef RESET_SEQ_SWRST_EN
    test_sw_done();
    test_sw_hold();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
